// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: two-channel dwell-limited arbiter driving a registered 2:1 mux select.
// Optional grant statistics counters are built when ARB_STATS_EN is defined.
module mux_sel_arbiter #(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic             done,
`ifdef ARB_STATS_EN
    input  logic             clr_stats,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
`endif
    output logic             s,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
    localparam logic [7:0] LP_DWELL = 8'(DWELL);
    state_t     r_state;
    logic [7:0] r_dwell;
    logic       r_pend;
    logic       r_last;
    logic       w_rel;
    logic       w_leave;
    logic       w_go0;
    logic       w_go1;
    logic       w_idle;
    always_comb begin
        w_rel   = (r_state == OWN0) ? (done | ~req0) : (done | ~req1);
        w_leave = (r_dwell == LP_DWELL) & (w_rel | r_pend);
        // a tie in IDLE goes to the channel that did not own the path last
        w_go0   = ((r_state == IDLE) & req0 & (~req1 | r_last)) | ((r_state == OWN1) & w_leave & req0);
        w_go1   = ((r_state == IDLE) & req1 & (~req0 | ~r_last)) | ((r_state == OWN0) & w_leave & req1);
        w_idle  = (r_state != IDLE) & w_leave & ~w_go0 & ~w_go1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_dwell <= '0;
            r_pend  <= 1'b0;
            r_last  <= 1'b1;
            s       <= 1'b0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            busy    <= 1'b0;
        end else if (w_go0 | w_go1) begin
            r_state <= w_go0 ? OWN0 : OWN1;
            r_dwell <= 8'd1;
            r_pend  <= 1'b0;
            r_last  <= w_go1;
            s       <= w_go1;
            gnt0    <= w_go0;
            gnt1    <= w_go1;
            busy    <= 1'b1;
        end else if (w_idle) begin
            r_state <= IDLE;
            r_dwell <= '0;
            r_pend  <= 1'b0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            busy    <= 1'b0;
        end else if (r_state != IDLE) begin
            if (r_dwell < LP_DWELL)
                r_dwell <= r_dwell + 8'd1;
            if (w_rel)
                r_pend <= 1'b1;
        end
    end
`ifdef ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            cnt0 <= clr_stats ? '0 : (w_go0 & ~&cnt0) ? cnt0 + 1'b1 : cnt0;
            cnt1 <= clr_stats ? '0 : (w_go1 & ~&cnt1) ? cnt1 + 1'b1 : cnt1;
        end
    end
`endif
endmodule

// File: tb/tb_mux_sel_arbiter.sv
// tb_mux_sel_arbiter: directed checks of mux_sel_arbiter (DWELL=4 and DWELL=1 instances).
module tb_mux_sel_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req0 = 1'b0, req1 = 1'b0, done = 1'b0;
    logic b_req0 = 1'b0, b_req1 = 1'b0, b_done = 1'b0;
    logic s, gnt0, gnt1, busy;
    logic b_s, b_gnt0, b_gnt1, b_busy;
    int   n_chk = 0;
    int   n_err = 0;
`ifdef ARB_STATS_EN
    logic       clr_stats = 1'b0;
    logic [1:0] cnt0, cnt1;
    logic [7:0] b_cnt0, b_cnt1;
`endif

    always #5 clk = ~clk;

    mux_sel_arbiter #(.DWELL(4), .CNT_W(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .done(done),
`ifdef ARB_STATS_EN
        .clr_stats(clr_stats), .cnt0(cnt0), .cnt1(cnt1),
`endif
        .s(s), .gnt0(gnt0), .gnt1(gnt1), .busy(busy)
    );

    mux_sel_arbiter #(.DWELL(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .req0(b_req0), .req1(b_req1), .done(b_done),
`ifdef ARB_STATS_EN
        .clr_stats(1'b0), .cnt0(b_cnt0), .cnt1(b_cnt1),
`endif
        .s(b_s), .gnt0(b_gnt0), .gnt1(b_gnt1), .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        {req0, req1, done, b_req0, b_req1, b_done} = '0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        chk("rst_grants", {s, gnt0, gnt1, busy}, 4'b0000);
        chk("rst_d1_grants", {b_s, b_gnt0, b_gnt1, b_busy}, 4'b0000);
`ifdef ARB_STATS_EN
        chk("rst_cnt", {cnt0, cnt1}, 4'b0000);
`endif
        // single request held one cycle: grant lasts exactly DWELL cycles
        req0 = 1'b1;
        tick();
        chk("one_gnt", {s, gnt0, gnt1, busy}, 4'b0101);
        req0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("one_hold", {gnt0, gnt1}, 2'b10);
        end
        tick();
        chk("one_idle", {s, gnt0, gnt1, busy}, 4'b0000);

        // tie from reset, early done latched until dwell expiry
        do_reset();
        {req0, req1} = 2'b11;
        tick();
        chk("tie_first", {s, gnt0, gnt1}, 3'b010);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("pend_hold2", {s, gnt0, gnt1}, 3'b010);
        tick();
        tick();
        chk("pend_hold4", {s, gnt0, gnt1}, 3'b010);
        tick();
        chk("handover", {s, gnt0, gnt1, busy}, 4'b1011);

        // continuous requests with done high: 4-cycle alternation, no bubble
        done = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            logic e1;
            tick();
            e1 = ((k / 4) % 2) == 0;
            chk("alt_gnt", {gnt0, gnt1, busy}, {~e1, e1, 1'b1});
            chk("alt_s", s, e1);
        end

        // asynchronous reset mid-grant (gnt1 high here)
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", {s, gnt0, gnt1, busy}, 4'b0000);
        {req0, req1, done} = '0;
        tick();
        rst_n = 1'b1;

        // s holds in IDLE; tie after channel 1 owned goes to channel 0
        req1 = 1'b1;
        tick();
        chk("own1_s", {s, gnt1}, 2'b11);
        req1 = 1'b0;
        repeat (4) tick();
        chk("idle_s_hold", {s, gnt0, gnt1, busy}, 4'b1000);
        {req0, req1} = 2'b11;
        tick();
        chk("tie_after1", {s, gnt0, gnt1}, 3'b010);
        {req0, req1} = 2'b00;

        // DWELL=1: one-cycle grant, one IDLE cycle, re-grant
        {b_req1, b_done} = 2'b11;
        tick();
        chk("d1_gnt", {b_s, b_gnt0, b_gnt1}, 3'b101);
        tick();
        chk("d1_idle", {b_gnt0, b_gnt1, b_busy}, 3'b000);
        tick();
        chk("d1_regnt", {b_gnt0, b_gnt1}, 2'b01);
        {b_req1, b_done} = 2'b00;

`ifdef ARB_STATS_EN
        // saturating 2-bit counter and clear
        do_reset();
        for (int i = 0; i < 5; i++) begin
            req0 = 1'b1;
            tick();
            req0 = 1'b0;
            chk("cnt0_inc", cnt0, (i < 3) ? i + 1 : 3);
            repeat (4) tick();
        end
        chk("cnt1_zero", cnt1, 0);
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        chk("cnt0_clr", cnt0, 0);
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/mux_sel_arbiter.md
MUX_SEL_ARBITER -- requirements
Module: mux_sel_arbiter

Interface
- REQ-001: Parameter DWELL, default 4: minimum cycles a grant is held (legal range 1..255).
- REQ-002: Parameter CNT_W, default 8: width of the grant statistics counters.
- REQ-003: clk  input  1  single clock; all state updates on the rising edge.
- REQ-004: rst_n  input  1  reset, asynchronous and active-low.
- REQ-005: req0  input  1  channel 0 (mux d0 source) requests the mux path.
- REQ-006: req1  input  1  channel 1 (mux d1 source) requests the mux path.
- REQ-007: done  input  1  current owner releases the path; single-cycle pulse or level.
- REQ-008: s  output  1  registered select driving the downstream 2:1 mux; 0 selects d0, 1 selects d1.
- REQ-009: gnt0 / gnt1  output  1 each  registered grant; at most one high in any cycle.
- REQ-010: busy  output  1  high whenever gnt0 or gnt1 is high.
- REQ-011: With ARB_STATS_EN only: clr_stats input 1; cnt0, cnt1 outputs CNT_W each.

Function
- REQ-012: States are IDLE, OWN0 and OWN1; gnt0=1 only in OWN0, gnt1=1 only in OWN1.
- REQ-013: s = 0 in OWN0 and s = 1 in OWN1; in IDLE, s holds its last value, so it changes only on an entry to OWN0/OWN1.
- REQ-014: IDLE with exactly one request sampled: go to that channel's OWN state; grant is visible 1 cycle after the sampled edge.
- REQ-015: IDLE with req0&req1: grant the channel that was NOT the last owner; the last-owner register resets to 1, so channel 0 wins the first tie.
- REQ-016: Dwell counter: loads 1 on entry to OWNx; increments each cycle while below DWELL; saturates at DWELL.
- REQ-017: Release condition in OWNx: (done==1 or reqx==0) sampled.
- REQ-018: A release seen before dwell expiry is latched (pending_rel) and acted on in the first cycle with dwell==DWELL.
- REQ-019: On release with the other channel requesting, go directly to the other OWN state (no IDLE bubble); s toggles in the same cycle the grant moves.
- REQ-020: On release with the other channel not requesting, go to IDLE; gnt0=gnt1=0 for at least 1 cycle.
- REQ-021: Re-arbitration in IDLE follows REQ-014/015 with no extra latency.
- REQ-022: done sampled in IDLE is ignored; pending_rel clears on every state change.
- REQ-023: DWELL=1 releases in the cycle after grant when the release condition holds.
- REQ-024: Grant outputs never overlap; a handover changes gnt0 and gnt1 in the same edge.

Reset
- REQ-025: rst_n low forces state=IDLE, s=0, gnt0=gnt1=0, busy=0, dwell=0, pending_rel=0, last-owner=1, and with stats cnt0=cnt1=0.
- REQ-026: Reset applies immediately, including mid-grant; first arbitration occurs on the first rising edge after rst_n rises.

Configuration
- REQ-027: Macro ARB_STATS_EN defined: cnt0/cnt1 increment by 1 on each entry to OWN0/OWN1, saturate at all-ones, and clear synchronously when clr_stats=1 (clear wins over a same-cycle increment).
- REQ-028: ARB_STATS_EN undefined: clr_stats, cnt0 and cnt1 are absent from the port list; the remaining behaviour is identical.

Verification
- REQ-029: Reset, then req0=1 for 1 cycle -> gnt0=1 and s=0 next cycle; gnt0 held exactly 4 cycles (DWELL=4); then IDLE.
- REQ-030: req0=req1=1 from reset -> OWN0 first; done pulse at cycle 2 of grant -> handover to OWN1 at dwell expiry; s goes 0->1 on the same edge gnt1 rises.
- REQ-031: Continuous req0=req1=1 and done held high -> grants alternate 0,1,0,1, each 4 cycles long, with no IDLE cycle and never both grants high.
- REQ-032: rst_n dropped while gnt1=1 -> gnt1=0 and s=0 asynchronously, before the next clock edge.
- REQ-033: DWELL=1, req1 only with done=1 -> gnt1 pulses for 1 cycle, followed by IDLE for 1 cycle, then a re-grant.
- REQ-034: ARB_STATS_EN with CNT_W=2 and 5 grants to channel 0 -> cnt0 reaches 3 and holds; clr_stats pulse -> cnt0=0 next cycle.
